// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a bouncy mechanical key for exercising a debouncer.
// A command moves key_out to cmd_level through 2*BOUNCE_MAX+1 toggles spaced by
// pseudo-random widths. The final level is then held for SETTLE_CYC cycles, and
// done pulses for one cycle.
//
// Parameters:
//   BOUNCE_MAX  extra toggle pairs before the final level (0 = clean edge)
//   GLITCH_MAX  max glitch width in cycles, power of two in 2..256
//   SETTLE_CYC  cycles the final level is held before done, >= 1
//   LFSR_SEED   non-zero reset value of the 16-bit LFSR
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  request to move key_out to cmd_level
//   cmd_level  target key level (1 = pressed)
//   cmd_ready  block is idle and can accept a command
//   key_out    emulated key output
//   busy       a command is in progress
//   done       one-cycle pulse when a command completes
module key_bounce_gen #(
  parameter int unsigned BOUNCE_MAX = 3,
  parameter int unsigned GLITCH_MAX = 16,
  parameter int unsigned SETTLE_CYC = 2500,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic key_out,
  output logic busy,
  output logic done
);

  localparam int unsigned TogTotal = 2 * BOUNCE_MAX + 1;
  localparam int unsigned TogW     = (TogTotal > 1) ? $clog2(TogTotal) : 1;
  localparam int unsigned GapW     = $clog2(GLITCH_MAX);
  localparam int unsigned SetW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // Toggles still owed after the first edge.
  localparam logic [TogW-1:0] TogLoad  = TogW'(2 * BOUNCE_MAX);
  localparam logic [SetW-1:0] SetLast  = SetW'(SETTLE_CYC - 1);
  localparam logic [7:0]      GapMask  = 8'(GLITCH_MAX - 1);

  typedef enum logic [1:0] {StIdle, StBounce, StSettle} state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_next;
  logic [TogW-1:0]   tog_q;
  logic [GapW-1:0]   gap_q;
  logic [GapW-1:0]   gap_load;
  logic [SetW-1:0]   set_q;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1; never reaches zero from a
  // non-zero seed.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // gap_q counts W-1 down to 0, so consecutive toggles are W cycles apart.
  assign gap_load = GapW'(lfsr_q[7:0] & GapMask);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_out <= 1'b0;
      done    <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      tog_q   <= '0;
      gap_q   <= '0;
      set_q   <= '0;
    end else begin
      lfsr_q <= lfsr_next;
      done   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            set_q <= '0;
            if (cmd_level != key_out) begin
              key_out <= cmd_level;
              if (TogLoad == '0) begin
                // Single clean edge: the first toggle is also the last.
                state_q <= StSettle;
              end else begin
                state_q <= StBounce;
                tog_q   <= TogLoad;
                gap_q   <= gap_load;
              end
            end else begin
              state_q <= StSettle;
            end
          end
        end
        StBounce: begin
          if (gap_q == '0) begin
            key_out <= ~key_out;
            if (tog_q == TogW'(1)) begin
              state_q <= StSettle;
              tog_q   <= '0;
              set_q   <= '0;
            end else begin
              tog_q <= tog_q - TogW'(1);
              gap_q <= gap_load;
            end
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end
        StSettle: begin
          if (set_q == SetLast) begin
            done    <= 1'b1;
            state_q <= StIdle;
            set_q   <= '0;
          end else begin
            set_q <= set_q + SetW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
module tb_key_bounce_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_valid, a_level, a_ready, a_key, a_busy, a_done;
  logic b_valid, b_level, b_ready, b_key, b_busy, b_done;

  key_bounce_gen #(.BOUNCE_MAX(3), .GLITCH_MAX(8), .SETTLE_CYC(20), .LFSR_SEED(16'hACE1)) u_a (
    .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_level(a_level),
    .cmd_ready(a_ready), .key_out(a_key), .busy(a_busy), .done(a_done)
  );

  key_bounce_gen #(.BOUNCE_MAX(0), .GLITCH_MAX(8), .SETTLE_CYC(20), .LFSR_SEED(16'hACE1)) u_b (
    .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_level(b_level),
    .cmd_ready(b_ready), .key_out(b_key), .busy(b_busy), .done(b_done)
  );

  // Simple debouncers: the LED follows the key once it is stable for 10 cycles,
  // longer than any glitch (<= 8) and shorter than the settle time (20).
  logic a_led, b_led;
  int   a_db, b_db;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_led <= 1'b0; a_db <= 0; b_led <= 1'b0; b_db <= 0;
    end else begin
      if (a_key == a_led) a_db <= 0;
      else if (a_db == 9) begin a_led <= a_key; a_db <= 0; end
      else a_db <= a_db + 1;
      if (b_key == b_led) b_db <= 0;
      else if (b_db == 9) begin b_led <= b_key; b_db <= 0; end
      else b_db <= b_db + 1;
    end
  end

  // Reference LFSR; m_prev holds the value present in the cycle before the last edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_lfsr <= 16'hACE1; m_prev <= 16'hACE1;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  int checks = 0;
  int errors = 0;

  int r_toggles, r_first_k, r_last_k, r_max_gap, r_gap_err;
  int r_done_k, r_done_cnt, r_led_chg;
  bit r_ready_at_done, r_accepted, r_final_key;

  // Issue one command and record edge timing relative to the accept edge (k = 0).
  task automatic run_cmd(input bit which, input bit level, input bit noise);
    bit prev_key, prev_led, key, led, lvl;
    int exp_gap;
    r_toggles = 0; r_first_k = -1; r_last_k = -1; r_max_gap = 0; r_gap_err = 0;
    r_done_k = -1; r_done_cnt = 0; r_led_chg = 0; r_ready_at_done = 0;
    lvl = level;
    exp_gap = 0;
    @(negedge clk);
    if (which) begin b_valid = 1'b1; b_level = lvl; end
    else begin a_valid = 1'b1; a_level = lvl; end
    r_accepted = which ? b_ready : a_ready;
    prev_key = which ? b_key : a_key;
    prev_led = which ? b_led : a_led;
    @(posedge clk); #1;
    if (!noise) begin a_valid = 1'b0; b_valid = 1'b0; end
    for (int k = 0; k < 400; k++) begin
      key = which ? b_key : a_key;
      led = which ? b_led : a_led;
      if (key !== prev_key) begin
        if (r_first_k < 0) r_first_k = k;
        else begin
          if (k - r_last_k > r_max_gap) r_max_gap = k - r_last_k;
          if (k - r_last_k != exp_gap) r_gap_err++;
        end
        exp_gap = 1 + int'(m_prev[7:0] & 8'h07);
        r_last_k = k;
        r_toggles++;
      end
      if (led !== prev_led) r_led_chg++;
      prev_key = key;
      prev_led = led;
      if ((which ? b_done : a_done) === 1'b1) begin
        r_done_cnt++;
        if (r_done_k < 0) begin
          r_done_k = k;
          r_ready_at_done = which ? b_ready : a_ready;
        end
        a_valid = 1'b0; b_valid = 1'b0;
      end
      if (r_done_k >= 0 && k >= r_done_k + 3) break;
      @(negedge clk);
      if (noise) begin
        lvl = ~lvl;
        if (which) b_level = lvl; else a_level = lvl;
      end
      @(posedge clk); #1;
    end
    r_final_key = which ? b_key : a_key;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_key !== 1'b0) begin errors++; $display("FAIL rst_key got %b want 0", a_key); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", a_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", a_done); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %b want 1", b_ready); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", a_ready); end
  endtask

  task automatic check_bounce(input string nm, input bit level);
    checks++; if (r_accepted !== 1'b1) begin errors++; $display("FAIL %s_ready_before got %b want 1", nm, r_accepted); end
    checks++; if (r_first_k != 0) begin errors++; $display("FAIL %s_first_edge got k=%0d want k=0", nm, r_first_k); end
    checks++; if (r_toggles != 7) begin errors++; $display("FAIL %s_toggles got %0d want 7", nm, r_toggles); end
    checks++; if (r_max_gap > 8) begin errors++; $display("FAIL %s_max_gap got %0d want <=8", nm, r_max_gap); end
    checks++; if (r_gap_err != 0) begin errors++; $display("FAIL %s_gap_model got %0d bad gaps want 0", nm, r_gap_err); end
    checks++; if (r_final_key !== level) begin errors++; $display("FAIL %s_final_key got %b want %b", nm, r_final_key, level); end
    checks++; if (r_done_k != r_last_k + 20 || r_last_k < 0) begin errors++; $display("FAIL %s_done_time got k=%0d want k=%0d", nm, r_done_k, r_last_k + 20); end
    checks++; if (r_done_cnt != 1) begin errors++; $display("FAIL %s_done_count got %0d want 1", nm, r_done_cnt); end
    checks++; if (r_ready_at_done !== 1'b1) begin errors++; $display("FAIL %s_ready_at_done got %b want 1", nm, r_ready_at_done); end
    checks++; if (r_led_chg != 1) begin errors++; $display("FAIL %s_led_changes got %0d want 1", nm, r_led_chg); end
  endtask

  task automatic test_press();
    run_cmd(1'b0, 1'b1, 1'b0);
    check_bounce("press", 1'b1);
  endtask

  task automatic test_release();
    run_cmd(1'b0, 1'b0, 1'b0);
    check_bounce("release", 1'b0);
  endtask

  task automatic test_same_level();
    run_cmd(1'b0, 1'b0, 1'b0);
    checks++; if (r_toggles != 0) begin errors++; $display("FAIL same_toggles got %0d want 0", r_toggles); end
    checks++; if (r_done_k != 20) begin errors++; $display("FAIL same_done_time got k=%0d want k=20", r_done_k); end
    checks++; if (r_done_cnt != 1) begin errors++; $display("FAIL same_done_count got %0d want 1", r_done_cnt); end
    checks++; if (r_led_chg != 0) begin errors++; $display("FAIL same_led_changes got %0d want 0", r_led_chg); end
  endtask

  task automatic test_busy_ignore();
    run_cmd(1'b0, 1'b1, 1'b1);
    checks++; if (r_toggles != 7) begin errors++; $display("FAIL noise_toggles got %0d want 7", r_toggles); end
    checks++; if (r_final_key !== 1'b1) begin errors++; $display("FAIL noise_final_key got %b want 1", r_final_key); end
    checks++; if (r_done_cnt != 1) begin errors++; $display("FAIL noise_done_count got %0d want 1", r_done_cnt); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL noise_busy_after got %b want 0", a_busy); end
    run_cmd(1'b0, 1'b0, 1'b0);
    checks++; if (r_final_key !== 1'b0) begin errors++; $display("FAIL back_to_back_key got %b want 0", r_final_key); end
  endtask

  task automatic test_reset_mid();
    int tog;
    bit prev;
    tog = 0;
    @(negedge clk);
    a_valid = 1'b1; a_level = 1'b1;
    prev = a_key;
    @(posedge clk); #1;
    a_valid = 1'b0;
    for (int k = 0; k < 100 && tog < 3; k++) begin
      if (a_key !== prev) tog++;
      prev = a_key;
      if (tog < 3) begin @(posedge clk); #1; end
    end
    checks++; if (tog != 3 || a_key !== 1'b1) begin errors++; $display("FAIL mid_pre_rst got tog=%0d key=%b want tog=3 key=1", tog, a_key); end
    #2; rst = 1'b1; #1;
    checks++; if (a_key !== 1'b0) begin errors++; $display("FAIL mid_rst_key got %b want 0", a_key); end
    checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b/%b want 1/0", a_ready, a_busy); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b want 1", a_ready); end
    tog = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_done === 1'b1) tog++;
      @(posedge clk); #1;
    end
    checks++; if (tog != 0 || a_key !== 1'b0) begin errors++; $display("FAIL mid_no_done got done=%0d key=%b want 0/0", tog, a_key); end
    run_cmd(1'b0, 1'b1, 1'b0);
    check_bounce("after_rst", 1'b1);
  endtask

  task automatic test_clean_edge();
    run_cmd(1'b1, 1'b1, 1'b0);
    checks++; if (r_toggles != 1 || r_first_k != 0) begin errors++; $display("FAIL clean_edge got toggles=%0d k=%0d want 1/0", r_toggles, r_first_k); end
    checks++; if (r_done_k != 20 || r_done_cnt != 1) begin errors++; $display("FAIL clean_done got k=%0d n=%0d want 20/1", r_done_k, r_done_cnt); end
    checks++; if (r_led_chg != 1 || b_led !== 1'b1) begin errors++; $display("FAIL clean_led got chg=%0d led=%b want 1/1", r_led_chg, b_led); end
    run_cmd(1'b1, 1'b0, 1'b0);
    checks++; if (r_toggles != 1 || r_final_key !== 1'b0) begin errors++; $display("FAIL clean_rel got toggles=%0d key=%b want 1/0", r_toggles, r_final_key); end
    checks++; if (r_led_chg != 1 || b_led !== 1'b0) begin errors++; $display("FAIL clean_rel_led got chg=%0d led=%b want 1/0", r_led_chg, b_led); end
  endtask

  initial begin
    a_valid = 1'b0; a_level = 1'b0; b_valid = 1'b0; b_level = 1'b0;
    test_reset();
    test_press();
    test_release();
    test_same_level();
    test_busy_ignore();
    test_reset_mid();
    test_clean_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
